// File: rtl/aurora_pkg.sv
// rtl/aurora_pkg.sv - Shared constants and LFSR helper for the Aurora 64b/66b scrambler
package aurora_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int BLOCK_W   = 66;
    localparam int PAYLOAD_W = 64;

    localparam int LFSR_W = 58;
    localparam int TAP_A  = 38;
    localparam int TAP_B  = 57;

    // Processes one payload bit at a time, bit 0 first, matching wire order.
    // Returns {updated lfsr, processed payload}. In descramble mode the LFSR
    // is fed with the received bit, which is what makes it self-synchronising.
    function automatic logic [LFSR_W+PAYLOAD_W-1:0] lfsr_step64(
        input logic [LFSR_W-1:0]    poly,
        input logic [PAYLOAD_W-1:0] data,
        input logic                 descramble
    );
        logic [LFSR_W-1:0]    p;
        logic [PAYLOAD_W-1:0] t;
        p = poly;
        t = '0;
        for (int i = 0; i < PAYLOAD_W; i++) begin
            t[i] = data[i] ^ p[TAP_A] ^ p[TAP_B];
            p    = {p[LFSR_W-2:0], (descramble ? data[i] : t[i])};
        end
        return {p, t};
    endfunction

endpackage

// File: rtl/aurora_tx_scrambler.sv
// rtl/aurora_tx_scrambler.sv - 64b/66b self-synchronous scrambler/descrambler, G(x)=1+x^39+x^58
module aurora_tx_scrambler
    import aurora_pkg::*;
#(
    parameter bit                DESCRAMBLE = 1'b0,
    parameter logic [LFSR_W-1:0] INIT_STATE = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [PAYLOAD_W-1:0] data_in,
    input  logic [1:0]           sync_info,
    input  logic                 enable,
    output logic [BLOCK_W-1:0]   data_out
);

    logic [LFSR_W-1:0]           poly;
    logic [LFSR_W+PAYLOAD_W-1:0] step;

    // Full 64-bit unrolled LFSR pass over the current payload
    always_comb begin
        step = lfsr_step64(poly, data_in, DESCRAMBLE);
    end

    // Register the block and advance the LFSR only on enabled cycles; sync header bypasses the LFSR
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_out <= '0;
            poly     <= INIT_STATE;
        end else if (enable) begin
            data_out <= {sync_info, step[PAYLOAD_W-1:0]};
            poly     <= step[LFSR_W+PAYLOAD_W-1:PAYLOAD_W];
        end
    end

endmodule

// File: tb/tb_aurora_tx_scrambler.sv
// tb/tb_aurora_tx_scrambler.sv - Scoreboard bench: scrambler, round-trip and self-sync descramblers
module tb_aurora_tx_scrambler;

    localparam logic [57:0] INIT_ONES = 58'h3FF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] data_in = '0;
    logic [1:0]  sync_info = 2'b01;
    logic        enable = 1'b0;
    logic        rx_en = 1'b0;
    logic [65:0] tx_out;
    logic [65:0] rx_out;
    logic [65:0] rx0_out;
    logic [63:0] rx_data;
    logic [1:0]  rx_sync;

    assign rx_data = tx_out[63:0];
    assign rx_sync = tx_out[65:64];

    always #5 clk = ~clk;

    aurora_tx_scrambler #(.DESCRAMBLE(1'b0), .INIT_STATE(INIT_ONES)) dut_tx (
        .clk_i(clk), .rst_n_i(rst_n), .data_in(data_in), .sync_info(sync_info),
        .enable(enable), .data_out(tx_out)
    );

    aurora_tx_scrambler #(.DESCRAMBLE(1'b1), .INIT_STATE(INIT_ONES)) dut_rx (
        .clk_i(clk), .rst_n_i(rst_n), .data_in(rx_data), .sync_info(rx_sync),
        .enable(rx_en), .data_out(rx_out)
    );

    aurora_tx_scrambler #(.DESCRAMBLE(1'b1), .INIT_STATE(58'h0)) dut_rx0 (
        .clk_i(clk), .rst_n_i(rst_n), .data_in(rx_data), .sync_info(rx_sync),
        .enable(rx_en), .data_out(rx0_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [65:0] exp_q[$];
    logic [65:0] src_q[$];
    logic [65:0] src0_q[$];
    logic [65:0] last_exp = '0;
    int          rx0_idx = 0;

    // Reference: the last 58 bits put on the wire, oldest first.
    // Before any traffic the LFSR contents stand in for that history.
    bit wire_hist[$];

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        wire_hist = {};
        for (int k = 57; k >= 0; k--) wire_hist.push_back(INIT_ONES[k]);
    endfunction

    // Each wire bit = payload bit xor the wire bits sent 39 and 58 bits earlier
    function automatic logic [63:0] model_scramble(input logic [63:0] d);
        logic [63:0] s;
        for (int n = 0; n < 64; n++) begin
            s[n] = d[n] ^ wire_hist[$-38] ^ wire_hist[$-57];
            wire_hist.push_back(s[n]);
            void'(wire_hist.pop_front());
        end
        return s;
    endfunction

    task automatic send(input logic [63:0] d, input logic [1:0] s);
        logic [63:0] sc;
        @(negedge clk);
        #2;
        data_in   = d;
        sync_info = s;
        enable    = 1'b1;
        sc = model_scramble(d);
        exp_q.push_back({s, sc});
        src_q.push_back({s, d});
        src0_q.push_back({s, d});
    endtask

    task automatic idle(input int n, input logic [63:0] d);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
            enable  = 1'b0;
            data_in = d;
        end
    endtask

    task automatic reset_pulse();
        idle(4, 64'h0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_tx", tx_out, 66'h0);
        check("async_reset_rx", rx_out, 66'h0);
        check("async_reset_rx0", rx0_out, 66'h0);
        last_exp = '0;
        rx0_idx  = 0;
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    // Scrambler monitor: compares on enabled cycles, otherwise checks the hold
    initial begin
        logic f;
        forever begin
            @(posedge clk);
            f = enable && rst_n;
            @(negedge clk);
            if (f) begin
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", tx_out, 66'hx);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("tx_block", tx_out, last_exp);
                end
            end else begin
                check("tx_hold", tx_out, last_exp);
            end
            rx_en = f;
        end
    end

    // Descrambler monitor: round trip must restore the source block
    initial begin
        logic        f;
        logic [65:0] e;
        forever begin
            @(posedge clk);
            f = rx_en && rst_n;
            @(negedge clk);
            if (f) begin
                if (src_q.size() == 0 || src0_q.size() == 0) begin
                    check("rx_unexpected", rx_out, 66'hx);
                end else begin
                    e = src_q.pop_front();
                    check("rx_roundtrip", rx_out, e);
                    e = src0_q.pop_front();
                    if (rx0_idx > 0) check("rx_selfsync", rx0_out, e);
                    rx0_idx++;
                end
            end
        end
    end

    initial begin
        logic [31:0] cnt;
        int          waited;
        model_reset();
        #1;
        check("reset_tx", tx_out, 66'h0);
        check("reset_rx", rx_out, 66'h0);
        #21 rst_n = 1'b1;
        idle(10, 64'h0);

        send(64'h0, 2'b01);
        idle(5, 64'hDEAD_BEEF_0000_0001);
        for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 2'b10);

        reset_pulse();
        send(64'h0, 2'b01);
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 2'($urandom_range(0, 3)));

        reset_pulse();
        cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            send({cnt, cnt}, (cnt % 64 == 0) ? 2'b01 : 2'b10);
            cnt++;
            if (k == 500) reset_pulse();
        end

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), {$urandom, $urandom});
            send({$urandom, $urandom}, 2'($urandom_range(0, 3)));
        end
        idle(4, 64'h0);

        waited = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (exp_q.size() != 0 || src_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d tx and %0d rx blocks still pending, expected 0", exp_q.size(), src_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
